// File: rtl/noc_flit_if_arbiter_mux.sv
// noc_flit_if_arbiter_mux: merges ENTRIES flit inputs onto one flit output.
// Each virtual channel arbitrates round-robin among input heads and stays
// locked to the winner from head to tail. Channels with a candidate are
// interleaved flit-by-flit, also round-robin. An output flit that is not
// accepted is held (same entry, channel and flit) until the handshake.
module noc_flit_if_arbiter_mux #(
  parameter int CHANNELS   = 2,
  parameter int ENTRIES    = 2,
  parameter int FLIT_WIDTH = 16,
  parameter int HEAD_BIT   = FLIT_WIDTH - 1,
  parameter int TAIL_BIT   = FLIT_WIDTH - 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ENTRIES-1:0][CHANNELS-1:0]     i_in_valid,
  input  logic [ENTRIES-1:0][FLIT_WIDTH-1:0]   i_in_flit,
  output logic [ENTRIES-1:0][CHANNELS-1:0]     o_in_ready,
  output logic [ENTRIES-1:0][CHANNELS-1:0]     o_in_vc_available,
  output logic [CHANNELS-1:0]                  o_out_valid,
  output logic [FLIT_WIDTH-1:0]                o_out_flit,
  input  logic [CHANNELS-1:0]                  i_out_ready,
  input  logic [CHANNELS-1:0]                  i_out_vc_available
);

  localparam int EW = (ENTRIES  > 1) ? $clog2(ENTRIES)  : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Per-channel lock state and round-robin pointers
  logic [CHANNELS-1:0]         r_locked;
  logic [CHANNELS-1:0][EW-1:0] r_owner;
  logic [CHANNELS-1:0][EW-1:0] r_rr_ptr;
  logic [CW-1:0]               r_vc_ptr;
  // Frozen selection while the output waits for ready
  logic                        r_hold;
  logic [EW-1:0]               r_hold_entry;
  logic [CW-1:0]               r_hold_vc;

  logic [CHANNELS-1:0]         w_cand_vld;
  logic [CHANNELS-1:0][EW-1:0] w_cand_entry;
  logic                        w_sel_any;
  logic [CW-1:0]               w_sel_vc;
  logic [EW-1:0]               w_sel_entry;
  logic [FLIT_WIDTH-1:0]       w_sel_flit;
  logic                        w_handshake;
  logic                        w_head;
  logic                        w_tail;
  logic [EW-1:0]               w_next_entry;
  logic [CW-1:0]               w_next_vc;
  logic [ENTRIES-1:0]          w_bad;

  // Per-channel candidate: the owner when locked, else first head from rr_ptr
  always_comb begin
    int idx;
    idx          = 0;
    w_cand_vld   = '0;
    w_cand_entry = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_locked[c]) begin
        w_cand_vld[c]   = i_in_valid[r_owner[c]][c];
        w_cand_entry[c] = r_owner[c];
      end else begin
        // Descending scan so the lowest offset from the pointer wins
        for (int off = ENTRIES - 1; off >= 0; off--) begin
          idx = int'(r_rr_ptr[c]) + off;
          if (idx >= ENTRIES) idx = idx - ENTRIES;
          if (i_in_valid[idx][c] && i_in_flit[idx][HEAD_BIT]) begin
            w_cand_vld[c]   = 1'b1;
            w_cand_entry[c] = EW'(idx);
          end
        end
      end
    end
  end

  // Channel selection: frozen selection while holding, else round-robin from vc_ptr
  always_comb begin
    int idx;
    idx         = 0;
    w_sel_any   = 1'b0;
    w_sel_vc    = '0;
    w_sel_entry = '0;
    if (r_hold) begin
      w_sel_any   = i_in_valid[r_hold_entry][r_hold_vc];
      w_sel_vc    = r_hold_vc;
      w_sel_entry = r_hold_entry;
    end else begin
      for (int off = CHANNELS - 1; off >= 0; off--) begin
        idx = int'(r_vc_ptr) + off;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (w_cand_vld[idx]) begin
          w_sel_any   = 1'b1;
          w_sel_vc    = CW'(idx);
          w_sel_entry = w_cand_entry[idx];
        end
      end
    end
  end

  assign w_sel_flit   = i_in_flit[w_sel_entry];
  assign w_head       = w_sel_flit[HEAD_BIT];
  assign w_tail       = w_sel_flit[TAIL_BIT];
  assign w_handshake  = !rst && w_sel_any && i_out_ready[w_sel_vc];
  assign w_next_entry = (w_sel_entry == EW'(ENTRIES - 1)) ? '0 : w_sel_entry + EW'(1);
  assign w_next_vc    = (w_sel_vc == CW'(CHANNELS - 1)) ? '0 : w_sel_vc + CW'(1);

  // Output is silenced during reset; valid never looks at ready
  assign o_out_valid = (!rst && w_sel_any) ? (CHANNELS'(1) << w_sel_vc) : '0;
  assign o_out_flit  = (!rst && w_sel_any) ? w_sel_flit : '0;

  // Input ready goes only to the selected entry, on its channel, at the handshake
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    assign o_in_ready[gi]        = (w_handshake && (w_sel_entry == EW'(gi)))
                                   ? (CHANNELS'(1) << w_sel_vc) : '0;
    assign o_in_vc_available[gi] = i_out_vc_available;
  end

  // Lock, pointer and hold update on the edge after the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked     <= '0;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_vc_ptr     <= '0;
      r_hold       <= 1'b0;
      r_hold_entry <= '0;
      r_hold_vc    <= '0;
    end else if (w_handshake) begin
      r_hold   <= 1'b0;
      r_vc_ptr <= w_next_vc;
      if (w_tail) begin
        r_locked[w_sel_vc] <= 1'b0;
        r_rr_ptr[w_sel_vc] <= w_next_entry;
      end else if (w_head) begin
        r_locked[w_sel_vc] <= 1'b1;
        r_owner[w_sel_vc]  <= w_sel_entry;
      end
    end else if (w_sel_any) begin
      r_hold       <= 1'b1;
      r_hold_entry <= w_sel_entry;
      r_hold_vc    <= w_sel_vc;
    end
  end

  // A body/tail flit offered on an idle channel is a protocol violation
  always_comb begin
    w_bad = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (i_in_valid[e][c] && !r_locked[c] && !i_in_flit[e][HEAD_BIT]) w_bad[e] = 1'b1;
      end
    end
  end

  a_no_idle_body: assert property (@(posedge clk) disable iff (rst) (w_bad == '0));

endmodule

// File: tb/tb_noc_flit_if_arbiter_mux.sv
// Directed testbench for noc_flit_if_arbiter_mux (ENTRIES=2, CHANNELS=2).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_noc_flit_if_arbiter_mux;

  localparam int CH = 2;
  localparam int EN = 2;
  localparam int FW = 16;

  logic                      clk;
  logic                      rst;
  logic [EN-1:0][CH-1:0]     in_valid;
  logic [EN-1:0][FW-1:0]     in_flit;
  logic [EN-1:0][CH-1:0]     in_ready;
  logic [EN-1:0][CH-1:0]     in_vc_av;
  logic [CH-1:0]             out_valid;
  logic [FW-1:0]             out_flit;
  logic [CH-1:0]             out_ready;
  logic [CH-1:0]             out_vc_av;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        r;     // reset this cycle
    logic [1:0]  v0;    // input 0 valid
    logic [15:0] f0;    // input 0 flit
    logic [1:0]  v1;    // input 1 valid
    logic [15:0] f1;    // input 1 flit
    logic [1:0]  ordy;  // output ready
    logic [1:0]  ev;    // expected output valid
    logic [15:0] ef;    // expected output flit
    logic [3:0]  erdy;  // expected {in1.ready, in0.ready}
  } vec_t;

  noc_flit_if_arbiter_mux #(
    .CHANNELS(CH), .ENTRIES(EN), .FLIT_WIDTH(FW), .HEAD_BIT(15), .TAIL_BIT(14)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_in_valid        (in_valid),
    .i_in_flit         (in_flit),
    .o_in_ready        (in_ready),
    .o_in_vc_available (in_vc_av),
    .o_out_valid       (out_valid),
    .o_out_flit        (out_flit),
    .i_out_ready       (out_ready),
    .i_out_vc_available(out_vc_av)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input bit h, input bit t, input logic [13:0] p);
    return {h, t, p};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    rst         = t.r;
    in_valid[0] = t.v0;
    in_flit[0]  = t.f0;
    in_valid[1] = t.v1;
    in_flit[1]  = t.f1;
    out_ready   = t.ordy;
  endtask

  task automatic idle_inputs();
    in_valid  = '0;
    in_flit   = '0;
    out_ready = 2'b11;
  endtask

  task automatic test_reset();
    // Head offered while reset is high must not appear or be granted
    rst = 1'b1;
    in_valid[0] = 2'b01;
    in_flit[0]  = mk(1, 0, 14'h7);
    @(negedge clk);
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp %b", out_valid, 2'b00); end
    checks++; if (out_flit !== 16'h0) begin errors++; $display("FAIL reset_flit got %h exp %h", out_flit, 16'h0); end
    checks++; if (in_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp %b", in_ready, 4'b0); end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL idle_valid got %b exp %b", out_valid, 2'b00); end
    $display("test_reset done");
    next_cycle();
  endtask

  task automatic test_single_packet();
    vec_t tv[$];
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h1), 2'b00, 16'h0, 2'b11, 2'b01, mk(1,0,14'h1), 4'b0001});
    tv.push_back('{1'b0, 2'b01, mk(0,0,14'h2), 2'b00, 16'h0, 2'b11, 2'b01, mk(0,0,14'h2), 4'b0001});
    tv.push_back('{1'b0, 2'b01, mk(0,1,14'h3), 2'b00, 16'h0, 2'b11, 2'b01, mk(0,1,14'h3), 4'b0001});
    // VC0 idle after the tail: input 1's single-flit packet goes through at once
    tv.push_back('{1'b0, 2'b00, 16'h0, 2'b01, mk(1,1,14'h4), 2'b11, 2'b01, mk(1,1,14'h4), 4'b0100});
    foreach (tv[k]) begin
      drive(tv[k]);
      @(negedge clk);
      checks++; if (out_valid !== tv[k].ev) begin errors++; $display("FAIL single[%0d] out_valid got %b exp %b", k, out_valid, tv[k].ev); end
      checks++; if (out_flit !== tv[k].ef) begin errors++; $display("FAIL single[%0d] out_flit got %h exp %h", k, out_flit, tv[k].ef); end
      checks++; if (in_ready !== tv[k].erdy) begin errors++; $display("FAIL single[%0d] in_ready got %b exp %b", k, in_ready, tv[k].erdy); end
      $display("single[%0d] out_valid=%b out_flit=%h in_ready=%b", k, out_valid, out_flit, in_ready);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_rr_contest();
    vec_t tv[$];
    // rr_ptr[0]=0: input 0 wins, its tail beats input 1's waiting head,
    // then input 1 wins the next contest with no bubble
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h10), 2'b01, mk(1,0,14'h20), 2'b11, 2'b01, mk(1,0,14'h10), 4'b0001});
    tv.push_back('{1'b0, 2'b01, mk(0,1,14'h11), 2'b01, mk(1,0,14'h20), 2'b11, 2'b01, mk(0,1,14'h11), 4'b0001});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h12), 2'b01, mk(1,0,14'h20), 2'b11, 2'b01, mk(1,0,14'h20), 4'b0100});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h12), 2'b01, mk(0,1,14'h21), 2'b11, 2'b01, mk(0,1,14'h21), 4'b0100});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h12), 2'b00, 16'h0,          2'b11, 2'b01, mk(1,0,14'h12), 4'b0001});
    tv.push_back('{1'b0, 2'b01, mk(0,1,14'h13), 2'b00, 16'h0,          2'b11, 2'b01, mk(0,1,14'h13), 4'b0001});
    foreach (tv[k]) begin
      drive(tv[k]);
      @(negedge clk);
      checks++; if (out_valid !== tv[k].ev) begin errors++; $display("FAIL rr[%0d] out_valid got %b exp %b", k, out_valid, tv[k].ev); end
      checks++; if (out_flit !== tv[k].ef) begin errors++; $display("FAIL rr[%0d] out_flit got %h exp %h", k, out_flit, tv[k].ef); end
      checks++; if (in_ready !== tv[k].erdy) begin errors++; $display("FAIL rr[%0d] in_ready got %b exp %b", k, in_ready, tv[k].erdy); end
      $display("rr[%0d] out_valid=%b out_flit=%h in_ready=%b", k, out_valid, out_flit, in_ready);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_interleave();
    logic [15:0] p0 [3];
    logic [15:0] p1 [3];
    logic [1:0]  exp_vc [6];
    int i0, i1;
    logic [15:0] ef;
    p0 = '{mk(1,0,14'h30), mk(0,0,14'h31), mk(0,1,14'h32)};
    p1 = '{mk(1,0,14'h40), mk(0,0,14'h41), mk(0,1,14'h42)};
    // vc_ptr is 1 here (every earlier handshake was on VC0)
    exp_vc = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid[0] = (i0 < 3) ? 2'b01 : 2'b00;
      in_flit[0]  = (i0 < 3) ? p0[i0] : 16'h0;
      in_valid[1] = (i1 < 3) ? 2'b10 : 2'b00;
      in_flit[1]  = (i1 < 3) ? p1[i1] : 16'h0;
      out_ready   = 2'b11;
      ef = (exp_vc[k] == 2'd0) ? p0[i0] : p1[i1];
      @(negedge clk);
      checks++; if (out_valid !== ((exp_vc[k] == 2'd0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL ilv[%0d] out_valid got %b exp vc %0d", k, out_valid, exp_vc[k]); end
      checks++; if (out_flit !== ef) begin errors++; $display("FAIL ilv[%0d] out_flit got %h exp %h", k, out_flit, ef); end
      checks++; if (in_ready !== ((exp_vc[k] == 2'd0) ? 4'b0001 : 4'b1000)) begin errors++; $display("FAIL ilv[%0d] in_ready got %b exp vc %0d", k, in_ready, exp_vc[k]); end
      $display("ilv[%0d] out_valid=%b out_flit=%h in_ready=%b", k, out_valid, out_flit, in_ready);
      if (exp_vc[k] == 2'd0) i0++; else i1++;
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    vec_t tv[$];
    // VC0 not ready for 4 cycles: selection frozen even when VC1 gets a candidate
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h50), 2'b00, 16'h0,          2'b10, 2'b01, mk(1,0,14'h50), 4'b0000});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h50), 2'b10, mk(1,1,14'h60), 2'b10, 2'b01, mk(1,0,14'h50), 4'b0000});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h50), 2'b10, mk(1,1,14'h60), 2'b10, 2'b01, mk(1,0,14'h50), 4'b0000});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h50), 2'b10, mk(1,1,14'h60), 2'b10, 2'b01, mk(1,0,14'h50), 4'b0000});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h50), 2'b10, mk(1,1,14'h60), 2'b11, 2'b01, mk(1,0,14'h50), 4'b0001});
    tv.push_back('{1'b0, 2'b01, mk(0,1,14'h51), 2'b10, mk(1,1,14'h60), 2'b11, 2'b10, mk(1,1,14'h60), 4'b1000});
    tv.push_back('{1'b0, 2'b01, mk(0,1,14'h51), 2'b00, 16'h0,          2'b11, 2'b01, mk(0,1,14'h51), 4'b0001});
    foreach (tv[k]) begin
      drive(tv[k]);
      @(negedge clk);
      checks++; if (out_valid !== tv[k].ev) begin errors++; $display("FAIL bp[%0d] out_valid got %b exp %b", k, out_valid, tv[k].ev); end
      checks++; if (out_flit !== tv[k].ef) begin errors++; $display("FAIL bp[%0d] out_flit got %h exp %h", k, out_flit, tv[k].ef); end
      checks++; if (in_ready !== tv[k].erdy) begin errors++; $display("FAIL bp[%0d] in_ready got %b exp %b", k, in_ready, tv[k].erdy); end
      $display("bp[%0d] out_valid=%b out_flit=%h in_ready=%b", k, out_valid, out_flit, in_ready);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    vec_t tv[$];
    // Lock VC0 to input 1, reset mid-packet, then input 0's head must win
    tv.push_back('{1'b0, 2'b00, 16'h0,          2'b01, mk(1,0,14'h70), 2'b11, 2'b01, mk(1,0,14'h70), 4'b0100});
    tv.push_back('{1'b1, 2'b01, mk(1,0,14'h80), 2'b01, mk(0,0,14'h71), 2'b11, 2'b00, 16'h0,          4'b0000});
    tv.push_back('{1'b0, 2'b01, mk(1,0,14'h80), 2'b00, 16'h0,          2'b11, 2'b01, mk(1,0,14'h80), 4'b0001});
    tv.push_back('{1'b0, 2'b01, mk(0,1,14'h81), 2'b00, 16'h0,          2'b11, 2'b01, mk(0,1,14'h81), 4'b0001});
    foreach (tv[k]) begin
      drive(tv[k]);
      @(negedge clk);
      checks++; if (out_valid !== tv[k].ev) begin errors++; $display("FAIL rstmid[%0d] out_valid got %b exp %b", k, out_valid, tv[k].ev); end
      checks++; if (out_flit !== tv[k].ef) begin errors++; $display("FAIL rstmid[%0d] out_flit got %h exp %h", k, out_flit, tv[k].ef); end
      checks++; if (in_ready !== tv[k].erdy) begin errors++; $display("FAIL rstmid[%0d] in_ready got %b exp %b", k, in_ready, tv[k].erdy); end
      $display("rstmid[%0d] out_valid=%b out_flit=%h in_ready=%b", k, out_valid, out_flit, in_ready);
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_vc_available();
    logic [1:0] pats [3];
    pats = '{2'b10, 2'b01, 2'b11};
    foreach (pats[k]) begin
      out_vc_av = pats[k];
      #1;
      checks++; if (in_vc_av[0] !== pats[k]) begin errors++; $display("FAIL vcav[%0d] in0 got %b exp %b", k, in_vc_av[0], pats[k]); end
      checks++; if (in_vc_av[1] !== pats[k]) begin errors++; $display("FAIL vcav[%0d] in1 got %b exp %b", k, in_vc_av[1], pats[k]); end
      $display("vcav[%0d] in0=%b in1=%b", k, in_vc_av[0], in_vc_av[1]);
    end
    next_cycle();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = 2'b11;
    out_vc_av = 2'b00;
    next_cycle();
    test_reset();
    test_single_packet();
    test_rr_contest();
    test_interleave();
    test_backpressure();
    test_reset_mid_packet();
    test_vc_available();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
